// File: rtl/tse_pcs_regs_pkg.sv
// Shared definitions for the PCS register-port initiator: register map,
// status/control bit positions, sequencer state encoding.
package tse_pcs_regs_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] REG_CONTROL       = 5'h00;
  localparam logic [ADDR_W-1:0] REG_STATUS        = 5'h01;
  localparam logic [ADDR_W-1:0] REG_DEV_ABILITY   = 5'h04;
  localparam logic [ADDR_W-1:0] REG_LINK_TIMER_LO = 5'h12;
  localparam logic [ADDR_W-1:0] REG_LINK_TIMER_HI = 5'h13;
  localparam logic [ADDR_W-1:0] REG_IF_MODE       = 5'h14;

  localparam int unsigned CTRL_RESET   = 15;
  localparam int unsigned STAT_LINK    = 2;
  localparam int unsigned STAT_AN_DONE = 5;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE        = 4'd0;
  localparam state_t ST_WR_IFMODE   = 4'd1;
  localparam state_t ST_WR_LT_LO    = 4'd2;
  localparam state_t ST_WR_LT_HI    = 4'd3;
  localparam state_t ST_WR_ABIL     = 4'd4;
  localparam state_t ST_WR_CTRL     = 4'd5;
  localparam state_t ST_POLL_RST    = 4'd6;
  localparam state_t ST_POLL_WAIT   = 4'd7;
  localparam state_t ST_POLL_STATUS = 4'd8;
  localparam state_t ST_ERROR       = 4'd9;

  // Test one bit of a register word by index.
  function automatic logic bit_set(input logic [DATA_W-1:0] word, input int unsigned idx);
    return |(word & (DATA_W'(1) << idx));
  endfunction

endpackage

// File: rtl/tse_reg_access.sv
// Single-access Avalon-MM master: owns read/write strobes, holds address and
// data through waitrequest, and times out a command stalled too long.
module tse_reg_access
  import tse_pcs_regs_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rd_nwr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              timeout,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest
);

  localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_active;

  assign w_active = read | write;
  assign ack      = w_active & ~waitrequest;
  assign timeout  = w_active & waitrequest & (r_stall_cnt == CNT_W'(WAIT_TIMEOUT));
  assign rdata    = readdata;

  // A new command may be accepted back-to-back in the cycle the previous one completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      address     <= '0;
      writedata   <= '0;
      read        <= 1'b0;
      write       <= 1'b0;
      r_stall_cnt <= '0;
    end else if (req && (!w_active || ack)) begin
      read        <= rd_nwr;
      write       <= ~rd_nwr;
      address     <= addr;
      writedata   <= wdata;
      r_stall_cnt <= '0;
    end else if (ack || timeout) begin
      read  <= 1'b0;
      write <= 1'b0;
    end else if (w_active && waitrequest) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tse_pcs_reg_init.sv
// PCS bring-up sequencer: writes IF_MODE, link timer, ability and control,
// waits for soft reset to clear, then periodically polls link/AN status.
module tse_pcs_reg_init
  import tse_pcs_regs_pkg::*;
#(
  parameter logic [15:0] IF_MODE_VAL     = 16'h0003,
  parameter logic [20:0] LINK_TIMER_VAL  = 21'd3125,
  parameter logic [15:0] DEV_ABILITY_VAL = 16'h4001,
  parameter logic [15:0] CTRL_VAL        = 16'h9340,
  parameter int unsigned POLL_INTERVAL   = 1000,
  parameter int unsigned WAIT_TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest,
  output logic              busy,
  output logic              link_up,
  output logic              an_done,
  output logic              error
);

  localparam int unsigned POLL_W = $clog2(POLL_INTERVAL + 1);

  state_t             r_state;
  logic               r_issued;
  logic               r_start_pend;
  logic [POLL_W-1:0]  r_poll_cnt;
  logic               r_busy;
  logic               r_link_up;
  logic               r_an_done;
  logic               r_error;

  state_t             w_state_nxt;
  logic               w_issued_nxt;
  logic               w_pend_nxt;
  logic [POLL_W-1:0]  w_poll_cnt_nxt;
  logic               w_busy_nxt;
  logic               w_link_nxt;
  logic               w_an_nxt;
  logic               w_error_nxt;
  logic               w_is_access;
  logic               w_can_accept;
  logic               w_req;
  logic               w_rd_nwr;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_ack;
  logic               w_timeout;
  logic [DATA_W-1:0]  w_rdata;

  assign busy    = r_busy;
  assign link_up = r_link_up;
  assign an_done = r_an_done;
  assign error   = r_error;

  tse_reg_access #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_access (
    .clk         (clk),
    .reset       (reset),
    .req         (w_req),
    .rd_nwr      (w_rd_nwr),
    .addr        (w_addr),
    .wdata       (w_wdata),
    .ack         (w_ack),
    .rdata       (w_rdata),
    .timeout     (w_timeout),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_issued     <= 1'b0;
      r_start_pend <= 1'b0;
      r_poll_cnt   <= '0;
      r_busy       <= 1'b0;
      r_link_up    <= 1'b0;
      r_an_done    <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_issued     <= w_issued_nxt;
      r_start_pend <= w_pend_nxt;
      r_poll_cnt   <= w_poll_cnt_nxt;
      r_busy       <= w_busy_nxt;
      r_link_up    <= w_link_nxt;
      r_an_done    <= w_an_nxt;
      r_error      <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_issued_nxt   = r_issued;
    w_pend_nxt     = r_start_pend;
    w_poll_cnt_nxt = r_poll_cnt;
    w_busy_nxt     = r_busy;
    w_link_nxt     = r_link_up;
    w_an_nxt       = r_an_done;
    w_error_nxt    = r_error;
    w_req          = 1'b0;
    w_is_access    = 1'b0;
    w_rd_nwr       = 1'b0;
    w_addr         = '0;
    w_wdata        = '0;
    w_can_accept   = 1'b0;

    // Command for the access owned by the current state.
    case (r_state)
      ST_WR_IFMODE:   begin w_is_access = 1'b1; w_addr = REG_IF_MODE;       w_wdata = IF_MODE_VAL; end
      ST_WR_LT_LO:    begin w_is_access = 1'b1; w_addr = REG_LINK_TIMER_LO; w_wdata = LINK_TIMER_VAL[15:0]; end
      ST_WR_LT_HI:    begin w_is_access = 1'b1; w_addr = REG_LINK_TIMER_HI; w_wdata = {11'd0, LINK_TIMER_VAL[20:16]}; end
      ST_WR_ABIL:     begin w_is_access = 1'b1; w_addr = REG_DEV_ABILITY;   w_wdata = DEV_ABILITY_VAL; end
      ST_WR_CTRL:     begin w_is_access = 1'b1; w_addr = REG_CONTROL;       w_wdata = CTRL_VAL; end
      ST_POLL_RST:    begin w_is_access = 1'b1; w_addr = REG_CONTROL;       w_rd_nwr = 1'b1; end
      ST_POLL_STATUS: begin w_is_access = 1'b1; w_addr = REG_STATUS;        w_rd_nwr = 1'b1; end
      default:        ;
    endcase

    w_can_accept = (r_state == ST_IDLE) || (r_state == ST_POLL_WAIT) || (r_state == ST_ERROR) ||
                   ((r_state == ST_POLL_STATUS) && !r_issued);

    if ((start || r_start_pend) && w_can_accept) begin
      w_state_nxt  = ST_WR_IFMODE;
      w_issued_nxt = 1'b0;
      w_pend_nxt   = 1'b0;
      w_busy_nxt   = 1'b1;
      w_link_nxt   = 1'b0;
      w_an_nxt     = 1'b0;
      w_error_nxt  = 1'b0;
    end else begin
      // A restart during an in-flight status read waits for that read to finish.
      if (start && (r_state == ST_POLL_STATUS)) begin
        w_pend_nxt = 1'b1;
      end
      if (w_is_access) begin
        if (!r_issued) begin
          w_req = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERROR;
          w_busy_nxt  = 1'b0;
          w_error_nxt = 1'b1;
        end else if (w_ack) begin
          w_poll_cnt_nxt = '0;
          case (r_state)
            ST_WR_IFMODE: w_state_nxt = ST_WR_LT_LO;
            ST_WR_LT_LO:  w_state_nxt = ST_WR_LT_HI;
            ST_WR_LT_HI:  w_state_nxt = ST_WR_ABIL;
            ST_WR_ABIL:   w_state_nxt = ST_WR_CTRL;
            ST_WR_CTRL:   w_state_nxt = ST_POLL_RST;
            ST_POLL_RST: begin
              if (bit_set(w_rdata, CTRL_RESET)) begin
                w_req = 1'b1;
              end else begin
                w_state_nxt = ST_POLL_WAIT;
                w_busy_nxt  = 1'b0;
              end
            end
            default: begin
              w_state_nxt = ST_POLL_WAIT;
              w_link_nxt  = bit_set(w_rdata, STAT_LINK);
              w_an_nxt    = bit_set(w_rdata, STAT_AN_DONE);
            end
          endcase
        end
        w_issued_nxt = w_req || (r_issued && !w_ack && !w_timeout);
      end else if (r_state == ST_POLL_WAIT) begin
        if (r_poll_cnt == POLL_W'(POLL_INTERVAL - 1)) begin
          w_state_nxt = ST_POLL_STATUS;
        end else begin
          w_poll_cnt_nxt = r_poll_cnt + POLL_W'(1);
        end
      end
    end
  end

endmodule
